// File: rtl/snoopy_vertical_fsm.sv
// Vertical motion FSM for the Snoopy sprite: ground, rise and fall.
// Optional air jump is enabled by defining SNOOPY_DOUBLE_JUMP_EN.
module snoopy_vertical_fsm #(
    parameter int GROUND_Y       = 100,
    parameter int JUMP_SPEED     = 6,
    parameter int GRAVITY        = 1,
    parameter int MAX_FALL_SPEED = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       input_jump,
    output logic [7:0] snoopy_y,
    output logic       on_ground
);

    typedef enum logic [1:0] {
        S_GROUND = 2'd0,
        S_RISE   = 2'd1,
        S_FALL   = 2'd2
    } state_t;

    localparam logic signed [9:0] GROUND_S = 10'(GROUND_Y);
    localparam logic signed [9:0] GRAV_S   = 10'(GRAVITY);
    localparam logic signed [9:0] MAXF_S   = 10'(MAX_FALL_SPEED);
    localparam logic [7:0]        JUMP_V   = 8'(-JUMP_SPEED);
    localparam logic [7:0]        GROUND_V = 8'(GROUND_Y);

    state_t            state;
    logic signed [7:0] y_speed;
    logic              jump_q;
    logic              jump_req;
    logic              jump_edge;
    logic              jump_now;
    logic signed [9:0] y_sum;
    logic signed [9:0] spd_sum;
    logic signed [7:0] spd_cap;
    logic              hit_ceiling;
    logic              hit_ground;
    logic              rise_done;
`ifdef SNOOPY_DOUBLE_JUMP_EN
    logic              air_jump_used;
    logic              air_jump;
`endif

    // Next-position arithmetic and bound checks, 10-bit signed to catch wrap
    always_comb begin
        jump_edge   = input_jump & ~jump_q;
        jump_now    = jump_req | jump_edge;
        y_sum       = $signed({2'b00, snoopy_y})
                    + $signed({{2{y_speed[7]}}, y_speed});
        spd_sum     = $signed({{2{y_speed[7]}}, y_speed}) + GRAV_S;
        spd_cap     = (spd_sum > MAXF_S) ? MAXF_S[7:0] : spd_sum[7:0];
        hit_ceiling = (y_sum < 10'sd0);
        hit_ground  = (state == S_FALL) && (y_sum >= GROUND_S);
        rise_done   = (spd_sum >= 10'sd0);
`ifdef SNOOPY_DOUBLE_JUMP_EN
        air_jump    = jump_now && !air_jump_used && !hit_ground;
`endif
    end

    // State, position and speed advance once per frame tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_GROUND;
            snoopy_y  <= GROUND_V;
            y_speed   <= '0;
            jump_q    <= 1'b0;
            jump_req  <= 1'b0;
            on_ground <= 1'b1;
`ifdef SNOOPY_DOUBLE_JUMP_EN
            air_jump_used <= 1'b0;
`endif
        end else begin
            jump_q   <= input_jump;
            jump_req <= frame_tick ? 1'b0 : jump_now;
            if (frame_tick) begin
                unique case (state)
                    S_GROUND: begin
                        if (jump_now) begin
                            y_speed   <= JUMP_V;
                            state     <= S_RISE;
                            on_ground <= 1'b0;
                        end
                    end
                    S_RISE, S_FALL: begin
                        if (hit_ceiling) begin
                            snoopy_y <= '0;
                            y_speed  <= '0;
                            state    <= S_FALL;
                        end else if (hit_ground) begin
                            snoopy_y  <= GROUND_V;
                            y_speed   <= '0;
                            state     <= S_GROUND;
                            on_ground <= 1'b1;
`ifdef SNOOPY_DOUBLE_JUMP_EN
                            air_jump_used <= 1'b0;
`endif
                        end else begin
                            snoopy_y <= y_sum[7:0];
                            y_speed  <= spd_cap;
                            if (state == S_RISE && rise_done)
                                state <= S_FALL;
                        end
`ifdef SNOOPY_DOUBLE_JUMP_EN
                        if (air_jump) begin
                            y_speed       <= JUMP_V;
                            state         <= S_RISE;
                            air_jump_used <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        state     <= S_GROUND;
                        on_ground <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snoopy_vertical_fsm.sv
// Bench for snoopy_vertical_fsm: vector table, corner sequences and
// randomized traffic against a frame-level motion model.
module tb_snoopy_vertical_fsm;

    localparam int GY = 100;
    localparam int JS = 6;
    localparam int GR = 1;
    localparam int MF = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       input_jump = 1'b0;
    logic [7:0] snoopy_y;
    logic       on_ground;

    logic       tick2 = 1'b0;
    logic       jump2 = 1'b0;
    logic [7:0] y2;
    logic       g2;

    int errors = 0;
    int checks = 0;

    // frame-level model of the default instance
    int m_y, m_v;
    bit m_air, m_used, m_req, m_prev;

    typedef struct {
        logic j;
        logic t;
        int   y;
        logic g;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    snoopy_vertical_fsm dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .input_jump (input_jump),
        .snoopy_y   (snoopy_y),
        .on_ground  (on_ground)
    );

    snoopy_vertical_fsm #(
        .GROUND_Y   (10),
        .JUMP_SPEED (20)
    ) dut_c (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (tick2),
        .input_jump (jump2),
        .snoopy_y   (y2),
        .on_ground  (g2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_y = GY; m_v = 0; m_air = 0; m_used = 0;
        m_req = 0; m_prev = 0;
    endtask

    task automatic model_step(input logic j, input logic t);
        bit e, rq, landed;
        int ny;
        e = j && !m_prev;
        m_prev = j;
        rq = m_req || e;
        landed = 0;
        if (!t) begin
            m_req = rq;
            return;
        end
        m_req = 0;
        if (!m_air) begin
            if (rq) begin
                m_v = -JS;
                m_air = 1;
            end
        end else begin
            ny = m_y + m_v;
            if (ny < 0) begin
                m_y = 0; m_v = 0;
            end else if (ny >= GY) begin
                m_y = GY; m_v = 0; m_air = 0; m_used = 0; landed = 1;
            end else begin
                m_y = ny;
                m_v = (m_v + GR > MF) ? MF : m_v + GR;
            end
`ifdef SNOOPY_DOUBLE_JUMP_EN
            if (!landed && rq && !m_used) begin
                m_v = -JS;
                m_used = 1;
            end
`endif
        end
    endtask

    task automatic step(input logic j, input logic t);
        input_jump = j;
        frame_tick = t;
        @(posedge clock);
        #1;
        model_step(j, t);
        frame_tick = 1'b0;
    endtask

    task automatic check_model(input string name);
        chk({name, "_y"}, int'(snoopy_y), m_y);
        chk({name, "_gnd"}, int'(on_ground), int'(!m_air));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        input_jump = 1'b0;
        frame_tick = 1'b0;
        tick2 = 1'b0;
        jump2 = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int ytraj[14];
        bit jl;
        ytraj = '{100, 94, 89, 85, 82, 80, 79, 79, 80, 82, 85, 89, 94, 100};

        // basic jump trajectory, edge in the same cycle as T0
        for (int i = 0; i < 14; i++)
            vecs.push_back('{j: (i == 0), t: 1'b1, y: ytraj[i], g: (i == 13)});

        do_reset();
        chk("rst_y", int'(snoopy_y), GY);
        chk("rst_gnd", int'(on_ground), 1);
        chk("rst_y2", int'(y2), 10);

        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("idle_y", int'(snoopy_y), GY);

        foreach (vecs[i]) begin
            step(vecs[i].j, vecs[i].t);
            chk($sformatf("traj%0d_y", i), int'(snoopy_y), vecs[i].y);
            chk($sformatf("traj%0d_gnd", i), int'(on_ground), int'(vecs[i].g));
        end

        // held button never retriggers
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
        chk("held_land_y", int'(snoopy_y), GY);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        chk("held_y", int'(snoopy_y), GY);
        chk("held_gnd", int'(on_ground), 1);
        step(1'b0, 1'b1);

        // no frame ticks mid-jump: everything frozen
        do_reset();
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("frz_pre", int'(snoopy_y), 85);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            if (snoopy_y !== 8'd85) chk("frz_hold", int'(snoopy_y), 85);
        end
        chk("frz_gnd", int'(on_ground), 0);
        step(1'b0, 1'b1);
        chk("frz_resume", int'(snoopy_y), 82);
        step(1'b0, 1'b1);
        chk("frz_resume2", int'(snoopy_y), 80);

        // asynchronous reset mid-jump
        do_reset();
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("ar_pre", int'(snoopy_y), 85);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_y", int'(snoopy_y), GY);
        chk("ar_gnd", int'(on_ground), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // ceiling clamp on a short screen
        jump2 = 1'b1; tick2 = 1'b1;
        @(posedge clock); #1;
        tick2 = 1'b0; jump2 = 1'b0;
        chk("ceil_t0_y", int'(y2), 10);
        chk("ceil_t0_gnd", int'(g2), 0);
        tick2 = 1'b1;
        @(posedge clock); #1;
        chk("ceil_t1_y", int'(y2), 0);
        chk("ceil_t1_gnd", int'(g2), 0);
        @(posedge clock); #1;
        chk("ceil_t2_y", int'(y2), 0);
        @(posedge clock); #1;
        chk("ceil_t3_y", int'(y2), 1);
        tick2 = 1'b0;

        // second edge at T4, then a third edge
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("dj_t4", int'(snoopy_y), 82);
        step(1'b0, 1'b1);
`ifdef SNOOPY_DOUBLE_JUMP_EN
        chk("dj_t5", int'(snoopy_y), 76);
`else
        chk("dj_t5", int'(snoopy_y), 80);
`endif
        step(1'b1, 1'b1);
        check_model("dj_t6");
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1);
            check_model("dj_tail");
        end
        chk("dj_end_gnd", int'(on_ground), 1);

        // randomized traffic against the model
        do_reset();
        jl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) jl = !jl;
            step(jl, ($urandom_range(0, 2) == 0));
            check_model("rnd");
            if (snoopy_y > 8'(GY)) chk("rnd_range", int'(snoopy_y), GY);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
